// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Two requesters (LSU, debug/DMA) share one single-port 128x32 memory.
package dmem_pkg;
  localparam int DMEM_ADDR_W = 7;
  localparam int DMEM_DATA_W = 32;

  localparam logic REQ_LSU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input arbiter: round-robin on last_grant, or fixed priority to requester 0.
// last_grant resets to REQ_DBG so the LSU wins the first tie.
module rr_arb2
  import dmem_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant,
  output logic       o_winner
);
  logic r_last_grant;
  logic w_winner;

  always_comb begin
    w_winner = REQ_LSU;
    if (FIXED_PRIO != 0)
      w_winner = i_req[0] ? REQ_LSU : REQ_DBG;
    else if (i_req == 2'b11)
      w_winner = ~r_last_grant;
    else
      w_winner = i_req[1] ? REQ_DBG : REQ_LSU;
  end

  assign o_grant  = i_req & (w_winner ? 2'b10 : 2'b01);
  assign o_winner = w_winner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_last_grant <= REQ_DBG;
    else if (i_accept) r_last_grant <= w_winner;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the LSU and the debug/DMA port.
// Each access runs IDLE (arbitrate) -> ISSUE (strobe) -> RESP (response pulse).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rsp_valid,
  output logic [DATA_W-1:0] r0_rsp_rdata,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] r1_rsp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t              r_state, w_state_nxt;
  logic                r_owner, r_we;
  logic                r_mem_read, r_mem_write;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic [1:0]          w_req, w_grant;
  logic                w_winner, w_idle, w_accept;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_resp;
  logic [DATA_W-1:0]   w_rdata;

  assign w_idle   = (r_state == S_IDLE);
  assign w_req    = {r1_valid, r0_valid};
  assign w_accept = w_idle & (|w_grant);

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_grant  (w_grant),
    .o_winner (w_winner)
  );

  assign r0_ready = w_idle & w_grant[0];
  assign r1_ready = w_idle & w_grant[1];

  assign w_sel_we    = w_winner ? r1_we    : r0_we;
  assign w_sel_addr  = w_winner ? r1_addr  : r0_addr;
  assign w_sel_wdata = w_winner ? r1_wdata : r0_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes default low so they live for exactly the ISSUE cycle; read and
  // write are derived from one bit and can never both be set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= REQ_LSU;
      r_we        <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      if (w_accept) begin
        r_owner     <= w_winner;
        r_we        <= w_sel_we;
        r_mem_read  <= ~w_sel_we;
        r_mem_write <= w_sel_we;
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
      end
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  assign w_resp  = (r_state == S_RESP);
  assign w_rdata = r_we ? '0 : mem_rdata;

  assign r0_rsp_valid = w_resp & (r_owner == REQ_LSU);
  assign r1_rsp_valid = w_resp & (r_owner == REQ_DBG);
  assign r0_rsp_rdata = r0_rsp_valid ? w_rdata : '0;
  assign r1_rsp_rdata = r1_rsp_valid ? w_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: round-robin instance (a) and fixed-priority instance (b),
// each with its own registered-read memory model cleared by reset.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r0_we, r1_valid, r1_we;
  logic [6:0]  r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;

  logic        a_r0_ready, a_r1_ready, a_r0_rsp_valid, a_r1_rsp_valid, a_mem_read, a_mem_write;
  logic [31:0] a_r0_rsp_rdata, a_r1_rsp_rdata, a_mem_wdata, a_mem_rdata;
  logic [6:0]  a_mem_addr;
  logic        b_r0_ready, b_r1_ready, b_r0_rsp_valid, b_r1_rsp_valid, b_mem_read, b_mem_write;
  logic [31:0] b_r0_rsp_rdata, b_r1_rsp_rdata, b_mem_wdata, b_mem_rdata;
  logic [6:0]  b_mem_addr;

  logic [31:0] mem_a [128];
  logic [31:0] mem_b [128];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.FIXED_PRIO(0)) u_a (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(a_r0_ready), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_rsp_valid(a_r0_rsp_valid), .r0_rsp_rdata(a_r0_rsp_rdata),
    .r1_valid(r1_valid), .r1_ready(a_r1_ready), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_rsp_valid(a_r1_rsp_valid), .r1_rsp_rdata(a_r1_rsp_rdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  dmem_arbiter #(.FIXED_PRIO(1)) u_b (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(b_r0_ready), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_rsp_valid(b_r0_rsp_valid), .r0_rsp_rdata(b_r0_rsp_rdata),
    .r1_valid(r1_valid), .r1_ready(b_r1_ready), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_rsp_valid(b_r1_rsp_valid), .r1_rsp_rdata(b_r1_rsp_rdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Memory model: read takes precedence, read data registered.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) mem_a[i] <= '0;
      a_mem_rdata <= '0;
    end else if (a_mem_read)  a_mem_rdata <= mem_a[a_mem_addr];
    else if (a_mem_write)     mem_a[a_mem_addr] <= a_mem_wdata;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < 128; j++) mem_b[j] <= '0;
      b_mem_rdata <= '0;
    end else if (b_mem_read)  b_mem_rdata <= mem_b[b_mem_addr];
    else if (b_mem_write)     mem_b[b_mem_addr] <= b_mem_wdata;
  end

  typedef struct packed {
    logic        v0, we0; logic [6:0] a0; logic [31:0] d0;
    logic        v1, we1; logic [6:0] a1; logic [31:0] d1;
    logic        rdy0, rdy1, rd, wr;
    logic [6:0]  maddr; logic [31:0] mwdata;
    logic        rv0, rv1; logic [31:0] rd0, rd1;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One arbitrated access = IDLE, ISSUE, RESP rows with inputs held throughout.
  task automatic add_acc(input logic v0, input logic we0, input logic [6:0] a0, input logic [31:0] d0,
                         input logic v1, input logic we1, input logic [6:0] a1, input logic [31:0] d1,
                         input logic win, input logic [31:0] exp_rd);
    vec_t v;
    v = '0;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.rdy0 = (win == 1'b0); v.rdy1 = (win == 1'b1);
    tbl.push_back(v);
    v.rdy0 = 1'b0; v.rdy1 = 1'b0;
    v.rd = win ? ~we1 : ~we0;
    v.wr = win ? we1 : we0;
    v.maddr = win ? a1 : a0;
    v.mwdata = win ? d1 : d0;
    tbl.push_back(v);
    v.rd = 1'b0; v.wr = 1'b0;
    v.rv0 = (win == 1'b0); v.rv1 = (win == 1'b1);
    v.rd0 = v.rv0 ? exp_rd : 32'h0;
    v.rd1 = v.rv1 ? exp_rd : 32'h0;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    r0_valid = v.v0; r0_we = v.we0; r0_addr = v.a0; r0_wdata = v.d0;
    r1_valid = v.v1; r1_we = v.we1; r1_addr = v.a1; r1_wdata = v.d1;
  endtask

  task automatic idle_inputs();
    r0_valid = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, " mem_read"},  a_mem_read, 0);
    chk({tag, " mem_write"}, a_mem_write, 0);
    chk({tag, " mem_addr"},  a_mem_addr, 0);
    chk({tag, " mem_wdata"}, a_mem_wdata, 0);
    chk({tag, " r0_ready"},  a_r0_ready, 0);
    chk({tag, " r1_ready"},  a_r1_ready, 0);
    chk({tag, " r0_rsp_valid"}, a_r0_rsp_valid, 0);
    chk({tag, " r1_rsp_valid"}, a_r1_rsp_valid, 0);
    chk({tag, " r0_rsp_rdata"}, a_r0_rsp_rdata, 0);
    chk({tag, " r1_rsp_rdata"}, a_r1_rsp_rdata, 0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #3;
    chk_a_zero("reset");
    chk("reset b_mem_read", b_mem_read, 0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;

    add_acc(1, 1, 7'h05, 32'hDEADBEEF, 0, 0, 7'h00, 32'h0,        0, 32'h0);
    add_acc(1, 0, 7'h05, 32'h0,        0, 0, 7'h00, 32'h0,        0, 32'hDEADBEEF);
    add_acc(0, 0, 7'h00, 32'h0,        1, 1, 7'h7F, 32'h12345678, 1, 32'h0);
    add_acc(1, 1, 7'h10, 32'hA5A50010, 0, 0, 7'h00, 32'h0,        0, 32'h0);
    add_acc(0, 0, 7'h00, 32'h0,        1, 1, 7'h11, 32'h5A5A0011, 1, 32'h0);
    add_acc(1, 0, 7'h10, 32'h0,        1, 0, 7'h11, 32'h0,        0, 32'hA5A50010);
    add_acc(1, 0, 7'h10, 32'h0,        1, 0, 7'h11, 32'h0,        1, 32'h5A5A0011);
    add_acc(1, 0, 7'h10, 32'h0,        1, 0, 7'h11, 32'h0,        0, 32'hA5A50010);
    add_acc(1, 0, 7'h10, 32'h0,        1, 0, 7'h11, 32'h0,        1, 32'h5A5A0011);
    add_acc(1, 0, 7'h7F, 32'h0,        0, 0, 7'h00, 32'h0,        0, 32'h12345678);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d r0_ready", i), a_r0_ready, tbl[i].rdy0);
      chk($sformatf("row%0d r1_ready", i), a_r1_ready, tbl[i].rdy1);
      chk($sformatf("row%0d mem_read", i), a_mem_read, tbl[i].rd);
      chk($sformatf("row%0d mem_write", i), a_mem_write, tbl[i].wr);
      chk($sformatf("row%0d strobe_overlap", i), a_mem_read & a_mem_write, 0);
      chk($sformatf("row%0d r0_rsp_valid", i), a_r0_rsp_valid, tbl[i].rv0);
      chk($sformatf("row%0d r1_rsp_valid", i), a_r1_rsp_valid, tbl[i].rv1);
      chk($sformatf("row%0d r0_rsp_rdata", i), a_r0_rsp_rdata, tbl[i].rd0);
      chk($sformatf("row%0d r1_rsp_rdata", i), a_r1_rsp_rdata, tbl[i].rd1);
      if (tbl[i].rd || tbl[i].wr) chk($sformatf("row%0d mem_addr", i), a_mem_addr, tbl[i].maddr);
      if (tbl[i].wr) chk($sformatf("row%0d mem_wdata", i), a_mem_wdata, tbl[i].mwdata);
    end

    // Reset during the strobe cycle of an r0 read of a populated address.
    @(posedge clk); #1;
    idle_inputs(); r0_valid = 1; r0_addr = 7'h10; #1;
    chk("midrst hs r0_ready", a_r0_ready, 1);
    @(posedge clk); #1;
    r0_valid = 0; #1;
    chk("midrst issue mem_read", a_mem_read, 1);
    reset = 1'b1; #1;
    chk_a_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      chk($sformatf("postrst%0d r0_rsp_valid", k), a_r0_rsp_valid, 0);
      chk($sformatf("postrst%0d mem_read", k), a_mem_read, 0);
    end
    @(posedge clk); #1;
    r0_valid = 1; r0_addr = 7'h10; r1_valid = 1; r1_addr = 7'h11; #1;
    chk("postrst tie r0_ready", a_r0_ready, 1);
    chk("postrst tie r1_ready", a_r1_ready, 0);
    @(posedge clk); #1;
    idle_inputs(); #1;
    chk("postrst mem_addr", a_mem_addr, 7'h10);
    @(posedge clk); #2;
    chk("postrst r0_rsp_valid", a_r0_rsp_valid, 1);
    chk("postrst cleared rdata", a_r0_rsp_rdata, 0);

    // Busy hold: r1 waits through ISSUE/RESP, r0 pulses valid for one cycle.
    @(posedge clk); #1;
    r0_valid = 1; r0_addr = 7'h20; #1;
    chk("busy hs r0_ready", a_r0_ready, 1);
    @(posedge clk); #1;
    r0_addr = 7'h33; r1_valid = 1; r1_addr = 7'h11; #1;
    chk("busy issue r0_ready", a_r0_ready, 0);
    chk("busy issue r1_ready", a_r1_ready, 0);
    chk("busy issue mem_addr", a_mem_addr, 7'h20);
    @(posedge clk); #1;
    r0_valid = 0; #1;
    chk("busy resp r1_ready", a_r1_ready, 0);
    chk("busy resp r0_rsp_valid", a_r0_rsp_valid, 1);
    @(posedge clk); #2;
    chk("busy idle r1_ready", a_r1_ready, 1);
    chk("busy idle r0_ready", a_r0_ready, 0);
    @(posedge clk); #1;
    r1_valid = 0; #1;
    chk("busy r1 mem_read", a_mem_read, 1);
    chk("busy r1 mem_addr", a_mem_addr, 7'h11);
    @(posedge clk); #2;
    chk("busy r1_rsp_valid", a_r1_rsp_valid, 1);
    chk("busy r0_rsp_valid", a_r0_rsp_valid, 0);
    @(posedge clk); #2;
    chk("busy no extra access", a_mem_read | a_mem_write, 0);

    // Fixed priority instance: r1 starves until r0 drops valid.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int g = 0; g < 3; g++) begin
      @(posedge clk); #1;
      r0_valid = 1; r0_addr = 7'h10; r1_valid = 1; r1_addr = 7'h11; #1;
      chk($sformatf("fp%0d r0_ready", g), b_r0_ready, 1);
      chk($sformatf("fp%0d r1_ready", g), b_r1_ready, 0);
      @(posedge clk); #2;
      chk($sformatf("fp%0d issue r1_ready", g), b_r1_ready, 0);
      chk($sformatf("fp%0d mem_addr", g), b_mem_addr, 7'h10);
      @(posedge clk); #1;
      if (g == 2) r0_valid = 0;
      #1;
      chk($sformatf("fp%0d r0_rsp_valid", g), b_r0_rsp_valid, 1);
      chk($sformatf("fp%0d r1_rsp_valid", g), b_r1_rsp_valid, 0);
    end
    @(posedge clk); #2;
    chk("fp r1 granted after r0 drops", b_r1_ready, 1);
    chk("fp r0_ready after drop", b_r0_ready, 0);
    @(posedge clk); #1;
    idle_inputs(); #1;
    chk("fp r1 mem_addr", b_mem_addr, 7'h11);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
